// File: rtl/decode_queue_pkg.sv
// Shared RV32IM decode types for the fetch -> decode -> dispatch path,
// plus the funct3-to-ALU-op mapping used by both OP and OP-IMM.
package decode_queue_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;
  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;

  typedef enum logic [1:0] {alu, mul, br, mem} op_type_t;

  typedef enum logic [3:0] {
    alu_none, alu_add, alu_sub, alu_sll, alu_slt, alu_sltu,
    alu_xor, alu_srl, alu_sra, alu_or, alu_and
  } alu_ops_t;

  typedef enum logic [1:0] {rs1_out, pc_out, no_out} alu_m1_sel_t;
  typedef enum logic       {rs2_out, imm_out} alu_m2_sel_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] order;
    logic        valid;
  } if_id_stage_reg_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] order;
    logic        valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    op_type_t    op_type;
    alu_ops_t    aluop;
    alu_m1_sel_t alu_m1_sel;
    alu_m2_sel_t alu_m2_sel;
    logic [2:0]  multop;
    logic        regf_we;
    logic        illegal;
  } id_dis_stage_reg_t;

  // alt only distinguishes add/sub and srl/sra; callers decide when it applies.
  function automatic alu_ops_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_ops_t op;
    case (funct3)
      3'b000:  op = alt ? alu_sub : alu_add;
      3'b001:  op = alu_sll;
      3'b010:  op = alu_slt;
      3'b011:  op = alu_sltu;
      3'b100:  op = alu_xor;
      3'b101:  op = alt ? alu_sra : alu_srl;
      3'b110:  op = alu_or;
      default: op = alu_and;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side bundle and dispatch-side window of the decode queue.
interface decode_queue_if import decode_queue_pkg::*; #(parameter int WIDTH = 2);
  localparam int DIS_W = $clog2(WIDTH + 1);

  if_id_stage_reg_t  [WIDTH-1:0] in_pkt;
  logic                          in_ready;
  id_dis_stage_reg_t [WIDTH-1:0] out_pkt;
  logic [DIS_W-1:0]              dis_count;

  modport master (output in_pkt, output dis_count, input in_ready, input out_pkt);
  modport slave  (input in_pkt, input dis_count, output in_ready, output out_pkt);
endinterface

// File: rtl/decode_queue_decode_lane.sv
// Purely combinational RV32IM decoder for one fetch lane.
module decode_lane
  import decode_queue_pkg::*;
(
  input  if_id_stage_reg_t  fetch,
  output id_dis_stage_reg_t decoded
);

  logic [31:0] inst;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  assign inst  = fetch.inst;
  assign i_imm = {{21{inst[31]}}, inst[30:20]};
  assign s_imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
  assign b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm = {inst[31:12], 12'h000};
  assign j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    decoded            = '0;
    decoded.inst       = inst;
    decoded.pc         = fetch.pc;
    decoded.order      = fetch.order;
    decoded.valid      = fetch.valid;
    decoded.opcode     = inst[6:0];
    decoded.funct3     = inst[14:12];
    decoded.funct7     = inst[31:25];
    decoded.rs1_addr   = inst[19:15];
    decoded.rs2_addr   = inst[24:20];
    decoded.rd_addr    = inst[11:7];
    decoded.op_type    = alu;
    decoded.aluop      = alu_none;
    decoded.alu_m1_sel = rs1_out;
    decoded.alu_m2_sel = rs2_out;
    case (inst[6:0])
      OP_LUI: begin
        decoded.imm = u_imm; decoded.alu_m1_sel = no_out; decoded.alu_m2_sel = imm_out;
        decoded.aluop = alu_add; decoded.regf_we = 1'b1;
      end
      OP_AUIPC: begin
        decoded.imm = u_imm; decoded.alu_m1_sel = pc_out; decoded.alu_m2_sel = imm_out;
        decoded.aluop = alu_add; decoded.regf_we = 1'b1;
      end
      OP_IMM: begin
        // Only the right-shift immediates carry a meaningful funct7.
        decoded.imm = i_imm; decoded.alu_m2_sel = imm_out; decoded.regf_we = 1'b1;
        decoded.aluop = alu_from_funct3(inst[14:12],
                                        (inst[14:12] == 3'b101) && (inst[31:25] == FUNCT7_ALT));
      end
      OP_REG: begin
        decoded.regf_we = 1'b1;
        if (inst[31:25] == FUNCT7_MUL) begin
          decoded.op_type = mul;
          decoded.multop  = inst[14:12];
        end else begin
          decoded.aluop = alu_from_funct3(inst[14:12], inst[31:25] == FUNCT7_ALT);
        end
      end
      OP_JAL: begin
        decoded.op_type = br; decoded.imm = j_imm; decoded.alu_m1_sel = pc_out;
        decoded.alu_m2_sel = imm_out; decoded.regf_we = 1'b1;
      end
      OP_JALR: begin
        decoded.op_type = br; decoded.imm = i_imm; decoded.alu_m2_sel = imm_out;
        decoded.regf_we = 1'b1;
      end
      OP_BR: begin
        decoded.op_type = br; decoded.imm = b_imm; decoded.alu_m1_sel = pc_out;
        decoded.alu_m2_sel = imm_out;
      end
      OP_LOAD: begin
        decoded.op_type = mem; decoded.imm = i_imm; decoded.alu_m2_sel = imm_out;
        decoded.regf_we = 1'b1;
      end
      OP_STORE: begin
        decoded.op_type = mem; decoded.imm = s_imm; decoded.alu_m2_sel = imm_out;
      end
      default: decoded.illegal = 1'b1;
    endcase
    if (!decoded.regf_we) decoded.rd_addr = '0;
  end

endmodule

// File: rtl/decode_queue.sv
// WIDTH-lane decode stage feeding a circular queue; valid lanes are compacted
// at the tail and dispatch pops from the head via dis_count.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  decode_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  id_dis_stage_reg_t             entries [DEPTH];
  id_dis_stage_reg_t             decoded [WIDTH];
  id_dis_stage_reg_t [WIDTH-1:0] out_lanes;
  logic [PTR_W-1:0]              head, tail;
  logic [PTR_W-1:0]              wr_addr [WIDTH];
  logic [CNT_W-1:0]              count, push_cnt, pop_cnt, dis_ext;
  logic                          ready, push_en;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    decode_lane u_lane (.fetch(bus.in_pkt[g]), .decoded(decoded[g]));
  end

  // Acceptance looks only at the start-of-cycle fill level, never at this cycle's pop.
  assign ready        = (DEPTH_C - count) >= WIDTH_C;
  assign push_en      = ready && !flush;
  assign bus.in_ready = ready;
  assign dis_ext      = CNT_W'(bus.dis_count);
  assign pop_cnt      = (dis_ext > count) ? count : dis_ext;

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      wr_addr[i] = tail + push_cnt[PTR_W-1:0];
      if (bus.in_pkt[i].valid) push_cnt = push_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head <= head + pop_cnt[PTR_W-1:0];
      if (push_en) begin
        tail  <= tail + push_cnt[PTR_W-1:0];
        count <= count + push_cnt - pop_cnt;
      end else begin
        count <= count - pop_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (bus.in_pkt[i].valid) entries[wr_addr[i]] <= decoded[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      out_lanes[i] = '0;
      if (CNT_W'(i) < count) out_lanes[i] = entries[head + PTR_W'(i)];
    end
  end

  assign bus.out_pkt = out_lanes;

endmodule
